// File: rtl/serterm_pkg.sv
// Shared constants and state encodings for the serial terminal receive path.
package serterm_pkg;

  localparam int unsigned DivisorDefault   = 104;
  localparam int unsigned DepthLog2Default = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/char_fifo.sv
// First-word-fall-through character buffer; a push into a full buffer is
// accepted only when the head is popped in the same cycle.
module char_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_q, rd_q;
  logic [7:0]          mem_q [Depth];
  logic                do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                   (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= i_data;
  end

  assign o_data = o_empty ? 8'h00 : mem_q[rd_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver: synchronizer, start/data/stop sampling FSM and a
// buffered FWFT character output with frame-error and overrun pulses.
module serial_rx
  import serterm_pkg::*;
#(
  parameter int unsigned DIVISOR    = DivisorDefault,
  parameter int unsigned DEPTH_LOG2 = DepthLog2Default
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_char,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned CntW = $clog2(DIVISOR);
  localparam logic [CntW-1:0] HalfLast = CntW'(DIVISOR / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(DIVISOR - 1);

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            push_req;
  logic            full, empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        // Edge detect, so a line stuck low cannot restart a frame.
        if (rx_prev_q && !rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_sync_q) push_req    = 1'b1;
          else           frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A full buffer still takes the byte when the consumer frees the head now.
  assign overrun_d = push_req && full && !i_ready;

  char_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_char_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_req),
    .i_data  (shift_q),
    .i_pop   (i_ready),
    .o_data  (o_char),
    .o_full  (full),
    .o_empty (empty)
  );

  assign o_valid     = !empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
